// File: rtl/set_job_sched.sv
// Job scheduler/sequencer for the SET candidate-counting engine.
// Optional watchdog on the engine run is enabled with SET_WDOG_EN.
module set_job_sched #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req0,
  input  logic [37:0]                job0,
  output logic                       gnt0,
  input  logic                       req1,
  input  logic [37:0]                job1,
  output logic                       gnt1,
  output logic                       set_en,
  output logic [23:0]                set_central,
  output logic [11:0]                set_radius,
  output logic [1:0]                 set_mode,
  input  logic                       set_busy,
  input  logic                       set_valid,
  input  logic [7:0]                 set_candidate,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [7:0]                 res_candidate,
  output logic                       res_src,
  output logic [TAG_W-1:0]           res_tag,
  output logic [$clog2(DEPTH+1)-1:0] fifo_cnt,
  output logic                       fifo_full
`ifdef SET_WDOG_EN
  ,
  output logic                       res_err
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = 38 + 1 + TAG_W;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    HOLD
  } state_t;

  state_t           state;
  logic [EW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             rr;
  logic [TAG_W-1:0] tag0;
  logic [TAG_W-1:0] tag1;
  logic             iss_src;
  logic [TAG_W-1:0] iss_tag;
  logic             empty;
  logic             push;
  logic             pop;
  logic [EW-1:0]    push_ent;
  logic [EW-1:0]    head;
`ifdef SET_WDOG_EN
  logic [7:0]       wd_cnt;
`endif

  assign fifo_full = (fifo_cnt == CW'(DEPTH));
  assign empty     = (fifo_cnt == '0);
  assign head      = mem[rd_ptr];
  assign pop       = (state == IDLE) && !empty && !set_busy;
  assign push      = gnt0 | gnt1;

  // rr picks the winner only on a tie; 0 favours req0
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!fifo_full) begin
      if (req0 && req1) begin
        gnt0 = !rr;
        gnt1 = rr;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  always_comb begin
    push_ent = {job0, 1'b0, tag0};
    if (gnt1) push_ent = {job1, 1'b1, tag1};
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_ent;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      rr       <= 1'b0;
      tag0     <= '0;
      tag1     <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        rr     <= !gnt1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) fifo_cnt <= fifo_cnt + 1'b1;
      if (pop && !push) fifo_cnt <= fifo_cnt - 1'b1;
      if (gnt0) tag0 <= tag0 + 1'b1;
      if (gnt1) tag1 <= tag1 + 1'b1;
    end
  end

  // operands stay in the issue registers until the next pop
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      set_en        <= 1'b0;
      set_central   <= '0;
      set_radius    <= '0;
      set_mode      <= '0;
      iss_src       <= 1'b0;
      iss_tag       <= '0;
      res_valid     <= 1'b0;
      res_candidate <= '0;
      res_src       <= 1'b0;
      res_tag       <= '0;
`ifdef SET_WDOG_EN
      res_err       <= 1'b0;
      wd_cnt        <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (pop) begin
            {set_mode, set_radius, set_central} <= head[EW-1 -: 38];
            iss_src <= head[TAG_W];
            iss_tag <= head[TAG_W-1:0];
            state   <= LAUNCH;
          end
        end
        LAUNCH: begin
          set_en <= 1'b1;
          state  <= WAIT;
`ifdef SET_WDOG_EN
          wd_cnt <= '0;
`endif
        end
        WAIT: begin
          set_en <= 1'b0;
          if (set_valid) begin
            res_candidate <= set_candidate;
            res_src       <= iss_src;
            res_tag       <= iss_tag;
            res_valid     <= 1'b1;
            state         <= HOLD;
          end
`ifdef SET_WDOG_EN
          else if (wd_cnt == 8'd199) begin
            res_candidate <= 8'hFF;
            res_src       <= iss_src;
            res_tag       <= iss_tag;
            res_err       <= 1'b1;
            res_valid     <= 1'b1;
            state         <= HOLD;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
`ifdef SET_WDOG_EN
            res_err   <= 1'b0;
`endif
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_set_job_sched.sv
// Scoreboard bench for set_job_sched with a behavioural SET engine model.
// Covers SET_WDOG_EN timeout when that macro is defined.
module tb_set_job_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, gnt0, gnt1;
  logic [37:0] job0, job1;
  logic        set_en, set_busy, set_valid;
  logic [23:0] set_central;
  logic [11:0] set_radius;
  logic [1:0]  set_mode;
  logic [7:0]  set_candidate;
  logic        res_valid, res_ready, res_src;
  logic [7:0]  res_candidate;
  logic [3:0]  res_tag;
  logic [2:0]  fifo_cnt;
  logic        fifo_full;
  logic        act_err;
`ifdef SET_WDOG_EN
  logic        res_err;
  assign act_err = res_err;
`else
  assign act_err = 1'b0;
`endif

  set_job_sched #(.DEPTH(4), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .job0(job0), .gnt0(gnt0),
    .req1(req1), .job1(job1), .gnt1(gnt1),
    .set_en(set_en), .set_central(set_central),
    .set_radius(set_radius), .set_mode(set_mode),
    .set_busy(set_busy), .set_valid(set_valid),
    .set_candidate(set_candidate),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_candidate(res_candidate), .res_src(res_src),
    .res_tag(res_tag), .fifo_cnt(fifo_cnt),
    .fifo_full(fifo_full)
`ifdef SET_WDOG_EN
    , .res_err(res_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] cand;
    logic       src;
    logic [3:0] tag;
    logic       err;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;
  int   tag_m[2];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic logic [37:0] mk(input logic [1:0] m,
                                     input logic [11:0] r,
                                     input logic [23:0] c);
    return {m, r, c};
  endfunction

  // Engine: diamond / square / r+c[3:0] / constant counts
  function automatic logic [7:0] cand_f(input logic [1:0] m,
                                        input logic [11:0] r,
                                        input logic [23:0] c);
    int ri;
    int v;
    ri = int'(r);
    unique case (m)
      2'd0: v = 2*ri*ri + 2*ri + 1;
      2'd1: v = (2*ri+1)*(2*ri+1);
      2'd2: v = ri + int'(c[3:0]);
      default: v = 90;
    endcase
    return v[7:0];
  endfunction

  logic        eng_mute = 1'b0;
  int          eng_cd;
  logic [23:0] lat_c;
  logic [11:0] lat_r;
  logic [1:0]  lat_m;

  always @(posedge clk) begin
    if (rst) begin
      set_busy      <= 1'b0;
      set_valid     <= 1'b0;
      set_candidate <= 8'd0;
      eng_cd        <= 0;
    end else begin
      set_valid <= 1'b0;
      if (set_en) begin
        set_busy <= 1'b1;
        eng_cd   <= 3;
        lat_c    <= set_central;
        lat_r    <= set_radius;
        lat_m    <= set_mode;
      end else if (set_busy && !eng_mute) begin
        if (eng_cd == 1) begin
          set_valid     <= 1'b1;
          set_busy      <= 1'b0;
          set_candidate <= cand_f(set_mode, set_radius, set_central);
        end else begin
          eng_cd <= eng_cd - 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && set_busy)
      chk("operand_hold", {set_mode, set_radius, set_central},
          {lat_m, lat_r, lat_c});
  end

  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (sbq.size() == 0) begin
        chk("unexpected_result", 64'(res_candidate), 64'hDEAD);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("result", {res_candidate, res_src, res_tag, act_err},
            {e.cand, e.src, e.tag, e.err});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input bit r0, input logic [37:0] j0,
                     input logic [7:0] c0, input bit r1,
                     input logic [37:0] j1, input logic [7:0] c1,
                     input logic [1:0] eg);
    req0 = r0; job0 = j0;
    req1 = r1; job1 = j1;
    @(negedge clk);
    chk("gnt", {gnt1, gnt0}, eg);
    if (eg[0]) begin
      sbq.push_back('{c0, 1'b0, 4'(tag_m[0]), 1'b0});
      tag_m[0]++;
    end
    if (eg[1]) begin
      sbq.push_back('{c1, 1'b1, 4'(tag_m[1]), 1'b0});
      tag_m[1]++;
    end
    tick();
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sbq.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain_left", 64'(sbq.size()), 64'd0);
    repeat (2) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sbq.delete();
    tag_m[0] = 0;
    tag_m[1] = 0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [37:0] z;
    int n;
    z = '0;
    rst = 1'b1; req0 = 0; req1 = 0; job0 = '0; job1 = '0;
    res_ready = 1'b1;
    tag_m[0] = 0; tag_m[1] = 0;
    tick(); tick();
    @(negedge clk);
    chk("reset_outputs",
        64'({set_en, set_central, set_radius, set_mode, res_valid,
             res_candidate, res_src, res_tag, fifo_cnt, fifo_full,
             act_err, gnt0, gnt1}), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // single job and launch latency
    cyc(1, mk(0, 2, 24'h004004), 8'd13, 0, z, 0, 2'b01);
    @(negedge clk);
    chk("t1_cnt1_en", {fifo_cnt, set_en}, {3'd1, 1'b0});
    tick();
    @(negedge clk);
    chk("t1_cnt0_en", {fifo_cnt, set_en}, {3'd0, 1'b0});
    tick();
    @(negedge clk);
    chk("t1_launch", {set_en, set_mode, set_radius, set_central},
        {1'b1, 2'd0, 12'd2, 24'h004004});
    tick();
    @(negedge clk);
    chk("t1_en_pulse", 64'(set_en), 64'd0);
    drain(50);
    @(negedge clk);
    chk("t1_cnt_end", 64'(fifo_cnt), 64'd0);

    // both requesters: alternate 0,1,0,1,0 then full
    do_reset();
    cyc(1, mk(1, 1, 24'h0), 8'd9,  1, mk(3, 7, 24'h0), 8'h5A, 2'b01);
    cyc(1, mk(2, 5, 24'h3), 8'd8,  1, mk(3, 7, 24'h0), 8'h5A, 2'b10);
    cyc(1, mk(2, 5, 24'h3), 8'd8,  1, mk(1, 3, 24'h0), 8'd49, 2'b01);
    cyc(1, mk(0, 3, 24'h0), 8'd25, 1, mk(1, 3, 24'h0), 8'd49, 2'b10);
    cyc(1, mk(0, 3, 24'h0), 8'd25, 1, mk(2, 1, 24'hF), 8'd16, 2'b01);
    cyc(1, mk(0, 0, 24'h0), 8'd1,  1, mk(2, 1, 24'hF), 8'd16, 2'b00);
    drain(200);

    // backpressure: fill FIFO behind a held result
    res_ready = 1'b0;
    cyc(1, mk(1, 0, 24'h0A0B0C), 8'd1, 0, z, 0, 2'b01);
    cyc(1, mk(1, 1, 24'h0), 8'd9,   0, z, 0, 2'b01);
    cyc(1, mk(1, 2, 24'h0), 8'd25,  0, z, 0, 2'b01);
    cyc(1, mk(1, 3, 24'h0), 8'd49,  0, z, 0, 2'b01);
    cyc(1, mk(1, 4, 24'h0), 8'd81,  0, z, 0, 2'b01);
    cyc(1, mk(1, 5, 24'h0), 8'd121, 0, z, 0, 2'b00);
    n = 0;
    @(negedge clk);
    while (!res_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t3_hold_reached", 64'(res_valid), 64'd1);
    chk("t3_full", {fifo_cnt, fifo_full}, {3'd4, 1'b1});
    req0 = 1'b1;
    job0 = mk(1, 5, 24'h0);
    for (int i = 0; i < 10; i++) begin
      tick();
      @(negedge clk);
      chk("t4_stall",
          {res_valid, res_candidate, set_en, gnt0,
           set_mode, set_radius, set_central},
          {1'b1, 8'd1, 1'b0, 1'b0, 2'd1, 12'd0, 24'h0A0B0C});
    end
    tick();
    res_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!gnt0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t3_gnt6", 64'(gnt0), 64'd1);
    sbq.push_back('{8'd121, 1'b0, 4'(tag_m[0]), 1'b0});
    tag_m[0]++;
    tick();
    req0 = 1'b0;
    drain(400);

    // reset while the engine runs
    cyc(0, z, 0, 1, mk(0, 4, 24'h123456), 8'd41, 2'b10);
    n = 0;
    @(negedge clk);
    while (!set_en && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t5_set_en_seen", 64'(set_en), 64'd1);
    tick();
    tick();
    do_reset();
    @(negedge clk);
    chk("t5_reset_outputs",
        64'({set_en, set_central, set_radius, set_mode, res_valid,
             res_candidate, res_src, res_tag, fifo_cnt, fifo_full,
             act_err}), 64'd0);
    tick();
    cyc(1, mk(2, 9, 24'h000007), 8'd16, 0, z, 0, 2'b01);
    drain(50);

`ifdef SET_WDOG_EN
    eng_mute = 1'b1;
    cyc(1, mk(0, 1, 24'h0), 8'd5, 0, z, 0, 2'b01);
    sbq[0].cand = 8'hFF;
    sbq[0].err  = 1'b1;
    drain(300);
    @(negedge clk);
    chk("wdog_err_clear", {res_valid, act_err}, 2'b00);
    eng_mute = 1'b0;
    do_reset();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/set_job_sched.md
Name: set_job_sched

Overview:
Job scheduler and sequencer for the SET candidate-counting engine.
- Two requesters submit jobs ({mode, radius, central}). A round-robin arbiter admits them into a DEPTH-entry job FIFO.
- An issue FSM launches one job at a time on the engine's en/busy/valid interface and holds the operands stable for the whole run.
- Results return tagged with source and sequence number over a valid/ready output port.
- Sits between the host-side job sources and the single SET engine instance.

Parameters:
DEPTH, 4, job FIFO entries (power of two, >=2).
TAG_W, 4, width of the per-source sequence tag.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous active-high reset.
req0  in  1  requester 0 has a job.
job0  in  38  requester 0 job: [37:36] mode, [35:24] radius, [23:0] central.
gnt0  out  1  job0 accepted this cycle (combinational).
req1  in  1  requester 1 has a job.
job1  in  38  requester 1 job, same layout as job0.
gnt1  out  1  job1 accepted this cycle (combinational).
set_en  out  1  engine start pulse.
set_central  out  24  engine central operand.
set_radius  out  12  engine radius operand.
set_mode  out  2  engine mode operand.
set_busy  in  1  engine busy.
set_valid  in  1  engine one-cycle result strobe.
set_candidate  in  8  engine count.
res_valid  out  1  result available.
res_ready  in  1  consumer accepts result.
res_candidate  out  8  captured count.
res_src  out  1  requester id of the job.
res_tag  out  TAG_W  sequence tag of the job.
fifo_cnt  out  $clog2(DEPTH+1)  FIFO occupancy.
fifo_full  out  1  fifo_cnt == DEPTH.

Behaviour:
- Reset (synchronous, rst high at an edge): FIFO empty; rr pointer = 0; both tag counters = 0; FSM = IDLE.
  - All outputs 0: set_en, set_central, set_radius, set_mode, res_valid, res_candidate, res_src, res_tag, fifo_cnt, fifo_full.
  - A job in flight is discarded. The engine shares rst.
- Arbitration:
  - gnt0/gnt1 = 0 when fifo_full.
  - Otherwise grant the single requester if only one req is high.
  - If both are high, grant the one the rr pointer selects (0 = req0).
  - After a grant, the pointer points to the other source.
  - At most one grant per cycle.
- Admission: on req&gnt, push {job, src, tag_src}, then tag_src += 1 (wraps modulo 2^TAG_W).
  - Push is blocked while full, even if a pop happens the same cycle.
  - Push and pop in the same cycle when not full leave fifo_cnt unchanged.
- Issue FSM (all engine outputs registered):
  - IDLE: if FIFO non-empty and !set_busy, pop head into the issue registers and drive set_central/radius/mode from them; go LAUNCH.
  - LAUNCH: set_en = 1 for exactly this cycle; go WAIT.
  - WAIT: set_en = 0; operands held unchanged. On set_valid: res_candidate <= set_candidate, res_src/res_tag from the issue registers, res_valid <= 1; go HOLD.
  - HOLD: on res_valid & res_ready, res_valid <= 0 and go IDLE. No new launch while in HOLD.
- Operands stay stable from LAUNCH until leaving WAIT. The engine computes from central/radius continuously, so this is mandatory.
- set_valid outside WAIT is ignored.
- set_busy high in IDLE stalls the issue.
- Latency, empty FIFO and idle FSM: job accepted at edge T → FIFO visible at T+1 → set_en high in cycle [T+2, T+3). res_valid rises on the edge after the set_valid pulse.
- Results leave in FIFO order. While res_ready is low, res_* hold stable.

Optional Feature:
SET_WDOG_EN: adds output port res_err (1 bit, reset 0) and an 8-bit counter.
- The counter clears on entering WAIT and increments each WAIT cycle.
- If it reaches 200 without set_valid: res_candidate = 8'hFF, res_err = 1, res_valid = 1; go HOLD.
- res_err clears with the res_valid handshake. A late set_valid is then ignored.
- Without the macro: no res_err port, no counter, and WAIT is unbounded.

Test Plan:
- Single job: req0, mode 0, central A=(4,4), radius A=2, res_ready=1 → set_en pulse 2 cycles after grant, then res_candidate=13, res_src=0, res_tag=0, fifo_cnt back to 0.
- req0 and req1 both held high with distinct jobs for 6 cycles → grants alternate 0,1,0,1,…; results in grant order; res_tag per source = 0,1,2.
- res_ready=0, submit 6 jobs → 1 job in HOLD plus 4 in FIFO; fifo_full=1 and gnt low for the 6th. Raise res_ready → all 6 results drain in order.
- res_ready low for 10 cycles in HOLD → res_valid/res_candidate stable, no set_en, operands unchanged.
- rst high for one cycle during WAIT → all outputs 0 next cycle, fifo_cnt=0. A later job returns tag 0.
- (SET_WDOG_EN) engine model never asserts set_valid → after 200 WAIT cycles res_valid=1, res_candidate=8'hFF, res_err=1.
